// File: rtl/dac_axis_out_buffer.sv
// Purpose: elastic FIFO stage from DDS to RFDC DAC AXI4-Stream. Prefills before streaming and inserts filler beats on starvation.
// Latency: the first beat is presented one cycle after occupancy reaches PREFILL; after that, one beat per advance.
// Backpressure: m00_axis_tready stalls the registered output. s_axis_tready = !full. Beats offered while full are dropped and counted.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   enable              1 = stream, 0 = stop and flush (counters kept)
//   underrun_mode       filler select: 0 = zero beat, 1 = repeat last popped beat
//   clear_counters      pulse, zeroes underrun_count and overflow_count
//   s_axis_*            sample beats from the DDS
//   m00_axis_*          registered beats to the RFDC
//   level               FIFO occupancy 0..DEPTH
//   state               0 IDLE, 1 PREFILL, 2 RUN, 3 UNDERRUN
//   underrun_count      filler beats emitted (saturating)
//   overflow_count      input beats dropped while full (saturating)
module dac_axis_out_buffer #(
    parameter int AXIS_DATA_WIDTH = 256,
    parameter int DEPTH           = 16,
    parameter int ADDR_WIDTH      = 4,
    parameter int PREFILL         = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       underrun_mode,
    input  logic                       clear_counters,
    input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    output logic [AXIS_DATA_WIDTH-1:0] m00_axis_tdata,
    output logic                       m00_axis_tvalid,
    input  logic                       m00_axis_tready,
    output logic [ADDR_WIDTH:0]        level,
    output logic [1:0]                 state,
    output logic [31:0]                underrun_count,
    output logic [31:0]                overflow_count
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PREFILL  = 2'd1,
        S_RUN      = 2'd2,
        S_UNDERRUN = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH_L   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] PREFILL_L = (ADDR_WIDTH + 1)'(PREFILL);
    localparam logic [ADDR_WIDTH:0] PTR_ONE   = (ADDR_WIDTH + 1)'(1);
    localparam logic [31:0]         CNT_MAX   = 32'hFFFF_FFFF;

    state_t state_q, state_d;

    // FIFO storage. Pointers carry one extra bit so that full (DEPTH) and empty (0) are distinguishable.
    logic [AXIS_DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]        wr_ptr_q;
    logic [ADDR_WIDTH:0]        rd_ptr_q;
    logic [ADDR_WIDTH:0]        level_w;
    logic                       full;
    logic                       empty;

    logic [AXIS_DATA_WIDTH-1:0] tdata_q;
    logic                       tvalid_q;
    logic [AXIS_DATA_WIDTH-1:0] last_q;

    logic [31:0] underrun_cnt_q;
    logic [31:0] overflow_cnt_q;

    logic advance;
    logic push;
    logic pop;
    logic load_head;
    logic load_fill;
    logic flush;
    logic ur_inc;
    logic ov_inc;

    assign level_w = wr_ptr_q - rd_ptr_q;
    assign full    = (level_w == DEPTH_L);
    assign empty   = (wr_ptr_q == rd_ptr_q);

    // The output register may take a new beat when it is empty or is being consumed this cycle.
    assign advance = !tvalid_q || m00_axis_tready;

    always_comb begin
        state_d   = state_q;
        push      = 1'b0;
        pop       = 1'b0;
        load_head = 1'b0;
        load_fill = 1'b0;
        flush     = 1'b0;
        ur_inc    = 1'b0;
        ov_inc    = 1'b0;

        if (!enable) begin
            // Stopping abandons everything in flight, including a stalled output beat.
            state_d = S_IDLE;
            flush   = 1'b1;
        end else begin
            if (state_q != S_IDLE) begin
                push   = s_axis_tvalid && !full;
                ov_inc = s_axis_tvalid && full;
            end

            case (state_q)
                S_IDLE: begin
                    flush   = 1'b1;
                    state_d = S_PREFILL;
                end
                S_PREFILL: begin
                    // Occupancy is sampled before this edge's push, so the head is always valid here.
                    if (level_w >= PREFILL_L) begin
                        pop       = 1'b1;
                        load_head = 1'b1;
                        state_d   = S_RUN;
                    end
                end
                S_RUN: begin
                    if (advance) begin
                        if (!empty) begin
                            pop       = 1'b1;
                            load_head = 1'b1;
                        end else begin
                            load_fill = 1'b1;
                            ur_inc    = 1'b1;
                            state_d   = S_UNDERRUN;
                        end
                    end
                end
                S_UNDERRUN: begin
                    // The first available beat ends the underrun; no re-prefill is done.
                    if (advance) begin
                        if (!empty) begin
                            pop       = 1'b1;
                            load_head = 1'b1;
                            state_d   = S_RUN;
                        end else begin
                            load_fill = 1'b1;
                            ur_inc    = 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            last_q   <= '0;
        end else begin
            state_q <= state_d;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                tdata_q  <= '0;
                tvalid_q <= 1'b0;
                last_q   <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PTR_ONE;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PTR_ONE;
                end
                if (load_head) begin
                    tdata_q  <= mem[rd_ptr_q[ADDR_WIDTH-1:0]];
                    last_q   <= mem[rd_ptr_q[ADDR_WIDTH-1:0]];
                    tvalid_q <= 1'b1;
                end else if (load_fill) begin
                    // last_q keeps the last real beat, so repeated fillers stay constant.
                    tdata_q  <= underrun_mode ? last_q : '0;
                    tvalid_q <= 1'b1;
                end
            end
        end
    end

    // Sample RAM: no reset needed, because occupancy is tracked only by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= s_axis_tdata;
        end
    end

    // Saturating counters. A clear on the same edge as an increment takes priority.
    always_ff @(posedge clk) begin
        if (reset || clear_counters) begin
            underrun_cnt_q <= '0;
            overflow_cnt_q <= '0;
        end else begin
            if (ur_inc && (underrun_cnt_q != CNT_MAX)) begin
                underrun_cnt_q <= underrun_cnt_q + 32'd1;
            end
            if (ov_inc && (overflow_cnt_q != CNT_MAX)) begin
                overflow_cnt_q <= overflow_cnt_q + 32'd1;
            end
        end
    end

    assign s_axis_tready   = !full;
    assign m00_axis_tdata  = tdata_q;
    assign m00_axis_tvalid = tvalid_q;
    assign level           = level_w;
    assign state           = state_q;
    assign underrun_count  = underrun_cnt_q;
    assign overflow_count  = overflow_cnt_q;

endmodule

// File: tb/tb_dac_axis_out_buffer.sv
// Purpose: self-checking bench for dac_axis_out_buffer (vector table plus multi-cycle sequences, with an output scoreboard).
// Latency: not applicable.
// Backpressure: m00_axis_tready is driven from the bench to create stalls.
module tb_dac_axis_out_buffer;

    localparam int W  = 256;
    localparam int AW = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           enable;
    logic           underrun_mode;
    logic           clear_counters;
    logic [W-1:0]   s_axis_tdata;
    logic           s_axis_tvalid;
    logic           s_axis_tready;
    logic [W-1:0]   m00_axis_tdata;
    logic           m00_axis_tvalid;
    logic           m00_axis_tready;
    logic [AW:0]    level;
    logic [1:0]     state;
    logic [31:0]    underrun_count;
    logic [31:0]    overflow_count;

    always #5 clk = ~clk;

    dac_axis_out_buffer #(
        .AXIS_DATA_WIDTH(W),
        .DEPTH(16),
        .ADDR_WIDTH(AW),
        .PREFILL(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .underrun_mode(underrun_mode),
        .clear_counters(clear_counters),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m00_axis_tdata(m00_axis_tdata),
        .m00_axis_tvalid(m00_axis_tvalid),
        .m00_axis_tready(m00_axis_tready),
        .level(level),
        .state(state),
        .underrun_count(underrun_count),
        .overflow_count(overflow_count)
    );

    typedef struct packed {
        logic        en;
        logic        vld;
        logic        rdy;
        logic [15:0] din;
        logic [1:0]  st;
        logic [4:0]  lvl;
        logic        tv;
        logic [15:0] dout;
    } vec_t;

    vec_t         tbl [11];
    int           n_pass = 0;
    int           n_chk  = 0;
    logic [W-1:0] sb_q [$];
    logic [W-1:0] prev_beat = '0;

    function automatic logic [W-1:0] beat(input logic [15:0] n);
        return {16{n}};
    endfunction

    function automatic vec_t mk(input logic en, input logic vld, input logic rdy, input logic [15:0] din,
                                input logic [1:0] st, input logic [4:0] lvl, input logic tv, input logic [15:0] dout);
        vec_t v;
        v.en = en; v.vld = vld; v.rdy = rdy; v.din = din;
        v.st = st; v.lvl = lvl; v.tv = tv; v.dout = dout;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Scores any handshake pending before the edge, then advances to 1 time unit after the edge.
    // Beats that are zero or repeat the previous beat are filler; every real beat in this bench is unique and nonzero.
    task automatic tick();
        if (!reset && m00_axis_tvalid && m00_axis_tready) begin
            if (m00_axis_tdata != '0 && m00_axis_tdata != prev_beat) begin
                if (sb_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL sb_unexpected: got %h expected no beat", m00_axis_tdata);
                end else begin
                    chk("sb_order", m00_axis_tdata, sb_q.pop_front());
                end
            end
            prev_beat = m00_axis_tdata;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vld, input logic [15:0] d, input logic expect_accept);
        s_axis_tvalid = vld;
        s_axis_tdata  = vld ? beat(d) : '0;
        if (vld && expect_accept) sb_q.push_back(beat(d));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; enable = 1'b0; underrun_mode = 1'b0; clear_counters = 1'b0;
        s_axis_tdata = '0; s_axis_tvalid = 1'b0; m00_axis_tready = 1'b1;

        // Prefill to first output and a single underrun, one row per cycle
        tbl[0]  = mk(1, 0, 1, 16'h0000, 2'd1, 5'd0, 0, 16'h0000);
        tbl[1]  = mk(1, 1, 1, 16'h0001, 2'd1, 5'd1, 0, 16'h0000);
        tbl[2]  = mk(1, 1, 1, 16'h0002, 2'd1, 5'd2, 0, 16'h0000);
        tbl[3]  = mk(1, 1, 1, 16'h0003, 2'd1, 5'd3, 0, 16'h0000);
        tbl[4]  = mk(1, 1, 1, 16'h0004, 2'd1, 5'd4, 0, 16'h0000);
        tbl[5]  = mk(1, 0, 1, 16'h0000, 2'd2, 5'd3, 1, 16'h0001);
        tbl[6]  = mk(1, 0, 1, 16'h0000, 2'd2, 5'd2, 1, 16'h0002);
        tbl[7]  = mk(1, 0, 1, 16'h0000, 2'd2, 5'd1, 1, 16'h0003);
        tbl[8]  = mk(1, 0, 1, 16'h0000, 2'd2, 5'd0, 1, 16'h0004);
        tbl[9]  = mk(1, 0, 1, 16'h0000, 2'd3, 5'd0, 1, 16'h0000);
        tbl[10] = mk(0, 0, 1, 16'h0000, 2'd0, 5'd0, 0, 16'h0000);

        repeat (3) tick();
        chk("rst_state", W'(state), W'(2'd0));
        chk("rst_level", W'(level), W'(5'd0));
        chk("rst_tvalid", W'(m00_axis_tvalid), W'(1'b0));
        chk("rst_tdata", m00_axis_tdata, '0);
        chk("rst_ucnt", W'(underrun_count), W'(32'd0));
        chk("rst_ocnt", W'(overflow_count), W'(32'd0));
        chk("rst_s_tready", W'(s_axis_tready), W'(1'b1));
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            enable          = tbl[i].en;
            m00_axis_tready = tbl[i].rdy;
            drive(tbl[i].vld, tbl[i].din, 1'b1);
            tick();
            chk($sformatf("tbl%0d_state", i), W'(state), W'(tbl[i].st));
            chk($sformatf("tbl%0d_level", i), W'(level), W'(tbl[i].lvl));
            chk($sformatf("tbl%0d_tvalid", i), W'(m00_axis_tvalid), W'(tbl[i].tv));
            chk($sformatf("tbl%0d_tdata", i), m00_axis_tdata, beat(tbl[i].dout));
        end
        chk("tbl_ucnt", W'(underrun_count), W'(32'd1));

        // Stall with input running: fill to 16, then drop 3 beats
        enable = 1'b1; m00_axis_tready = 1'b0; drive(1'b0, 16'h0, 1'b0);
        tick();
        chk("ovf_prefill_state", W'(state), W'(2'd1));
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 16'h0100 + 16'(i), i < 17);
            tick();
            if (i == 10) chk("ovf_frozen_tdata", m00_axis_tdata, beat(16'h0100));
        end
        drive(1'b0, 16'h0, 1'b0);
        chk("ovf_level", W'(level), W'(5'd16));
        chk("ovf_count", W'(overflow_count), W'(32'd3));
        chk("ovf_s_tready", W'(s_axis_tready), W'(1'b0));
        chk("ovf_tvalid", W'(m00_axis_tvalid), W'(1'b1));
        chk("ovf_tdata", m00_axis_tdata, beat(16'h0100));
        chk("ovf_state", W'(state), W'(2'd2));

        // Drain into zero-filler underrun
        m00_axis_tready = 1'b1;
        repeat (20) tick();
        chk("drain_state", W'(state), W'(2'd3));
        chk("drain_level", W'(level), W'(5'd0));
        chk("drain_tdata", m00_axis_tdata, '0);
        chk("drain_ucnt", W'(underrun_count), W'(32'd5));

        // One filler per cycle, then resume on a single beat
        repeat (5) tick();
        chk("ur_ucnt", W'(underrun_count), W'(32'd10));
        drive(1'b1, 16'hA5A5, 1'b1);
        tick();
        chk("resume_push_state", W'(state), W'(2'd3));
        chk("resume_push_level", W'(level), W'(5'd1));
        chk("resume_push_ucnt", W'(underrun_count), W'(32'd11));
        drive(1'b0, 16'h0, 1'b0);
        tick();
        chk("resume_state", W'(state), W'(2'd2));
        chk("resume_tdata", m00_axis_tdata, beat(16'hA5A5));
        chk("resume_ucnt", W'(underrun_count), W'(32'd11));
        tick();
        chk("reur_state", W'(state), W'(2'd3));
        chk("reur_tdata", m00_axis_tdata, '0);
        chk("reur_ucnt", W'(underrun_count), W'(32'd12));

        // Hold-last filler
        drive(1'b1, 16'h1234, 1'b1);
        tick();
        drive(1'b0, 16'h0, 1'b0);
        tick();
        chk("hold_real_tdata", m00_axis_tdata, beat(16'h1234));
        chk("hold_real_ucnt", W'(underrun_count), W'(32'd13));
        underrun_mode = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("hold_fill%0d_tdata", k), m00_axis_tdata, beat(16'h1234));
        end
        chk("hold_state", W'(state), W'(2'd3));
        chk("hold_ucnt", W'(underrun_count), W'(32'd17));

        // Disable mid-RUN with level 7
        m00_axis_tready = 1'b1;
        drive(1'b1, 16'h0200, 1'b1);
        tick();
        drive(1'b1, 16'h0201, 1'b1);
        tick();
        m00_axis_tready = 1'b0;
        for (int i = 2; i < 8; i++) begin
            drive(1'b1, 16'h0200 + 16'(i), 1'b1);
            tick();
        end
        chk("dis_pre_state", W'(state), W'(2'd2));
        chk("dis_pre_level", W'(level), W'(5'd7));
        chk("dis_pre_tdata", m00_axis_tdata, beat(16'h0200));
        enable = 1'b0; drive(1'b0, 16'h0, 1'b0);
        tick();
        sb_q.delete();
        chk("dis_state", W'(state), W'(2'd0));
        chk("dis_level", W'(level), W'(5'd0));
        chk("dis_tvalid", W'(m00_axis_tvalid), W'(1'b0));
        chk("dis_tdata", m00_axis_tdata, '0);
        chk("dis_ucnt", W'(underrun_count), W'(32'd18));
        chk("dis_ocnt", W'(overflow_count), W'(32'd3));

        // Re-enable: a beat offered in IDLE is discarded uncounted, then a full prefill is needed
        underrun_mode = 1'b0; m00_axis_tready = 1'b1; enable = 1'b1;
        drive(1'b1, 16'h0999, 1'b0);
        tick();
        chk("reen_state", W'(state), W'(2'd1));
        chk("reen_level", W'(level), W'(5'd0));
        chk("reen_ocnt", W'(overflow_count), W'(32'd3));
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 16'h0300 + 16'(i), 1'b1);
            tick();
            chk($sformatf("reen_pf%0d_tvalid", i), W'(m00_axis_tvalid), W'(1'b0));
            chk($sformatf("reen_pf%0d_state", i), W'(state), W'(2'd1));
        end
        drive(1'b0, 16'h0, 1'b0);
        tick();
        chk("reen_run_state", W'(state), W'(2'd2));
        chk("reen_run_tdata", m00_axis_tdata, beat(16'h0300));
        repeat (6) tick();
        chk("reen_ur_state", W'(state), W'(2'd3));
        chk("reen_ur_ucnt", W'(underrun_count), W'(32'd21));

        // Saturation and clear priority
        m00_axis_tready = 1'b0;
        tick();
        force dut.underrun_cnt_q = 32'hFFFF_FFFE;
        tick();
        release dut.underrun_cnt_q;
        chk("sat_preset", W'(underrun_count), W'(32'hFFFF_FFFE));
        m00_axis_tready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("sat%0d_ucnt", k), W'(underrun_count), W'(32'hFFFF_FFFF));
        end
        clear_counters = 1'b1;
        tick();
        clear_counters = 1'b0;
        chk("clr_ucnt", W'(underrun_count), W'(32'd0));
        chk("clr_ocnt", W'(overflow_count), W'(32'd0));
        tick();
        chk("post_clr_ucnt", W'(underrun_count), W'(32'd1));
        chk("sb_empty", W'(sb_q.size()), W'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
